// File: rtl/alto_muldiv_seq.sv
// Multi-cycle MUL/DIV sequencer driving the shared 16-bit Alto ALU, one ALU pass per cycle.
// MUL: {hi,lo} = a*b + c (shift-add, LSB first). DIV: {c,a} / b (restoring, MSB first).
module alto_muldiv_seq (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic        op_i,
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic [15:0] c_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] hi_o,
   output logic [15:0] lo_o,
   output logic        ovf_o,
   output logic        skip_o,
   output logic [3:0]  alu_aluf_o,
   output logic [15:0] alu_bus_o,
   output logic [15:0] alu_t_o,
   output logic        alu_skip_o,
   input  logic [15:0] alu_output_i,
   input  logic        alu_carry_i
);

   localparam logic [3:0] ALUF_BUS         = 4'd0;
   localparam logic [3:0] ALUF_BUS_PLUS_T  = 4'd7;
   localparam logic [3:0] ALUF_BUS_MINUS_T = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DCHK,
      ST_DIV
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] hi_q, hi_d;
   logic [15:0] lo_q, lo_d;
   logic [15:0] d_q, d_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic        skip_q, skip_d;
   logic        done_q, done_d;

   logic        div_m;
   logic [15:0] div_s;
   logic        div_q;

   // Shifted partial remainder; div_m is the bit shifted out of hi.
   assign div_m = hi_q[15];
   assign div_s = {hi_q[14:0], lo_q[15]};
   assign div_q = div_m | alu_carry_i;

   always_comb begin
      state_d    = state_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      d_d        = d_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      skip_d     = skip_q;
      done_d     = 1'b0;
      alu_aluf_o = ALUF_BUS;
      alu_bus_o  = '0;
      alu_t_o    = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               hi_d    = c_i;
               lo_d    = a_i;
               d_d     = b_i;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               skip_d  = 1'b0;
               state_d = op_i ? ST_DCHK : ST_MUL;
            end
         end

         ST_MUL: begin
            alu_bus_o = hi_q;
            if (lo_q[0]) begin
               alu_aluf_o = ALUF_BUS_PLUS_T;
               alu_t_o    = d_q;
            end
            hi_d  = {alu_carry_i & lo_q[0], alu_output_i[15:1]};
            lo_d  = {alu_output_i[0], lo_q[15:1]};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end

         ST_DCHK: begin
            alu_aluf_o = ALUF_BUS_MINUS_T;
            alu_bus_o  = hi_q;
            alu_t_o    = d_q;
            if (alu_carry_i) begin
               ovf_d   = 1'b1;
               skip_d  = 1'b0;
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d   = '0;
               state_d = ST_DIV;
            end
         end

         ST_DIV: begin
            alu_aluf_o = ALUF_BUS_MINUS_T;
            alu_bus_o  = div_s;
            alu_t_o    = d_q;
            hi_d       = div_q ? alu_output_i : div_s;
            lo_d       = {lo_q[14:0], div_q};
            cnt_d      = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               ovf_d   = 1'b0;
               skip_d  = 1'b1;
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         skip_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         skip_q  <= skip_d;
         done_q  <= done_d;
      end
   end

   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = done_q;
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;
   assign ovf_o      = ovf_q;
   assign skip_o     = skip_q;
   assign alu_skip_o = 1'b0;

endmodule
